// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 64-bit ALU between two valid/ready requesters.
// A round-robin grant picks one request in IDLE, the operands are latched,
// the ALU result is registered in EXEC and held in RESP until the owner
// takes it. A saturating counter tracks how many operations overflowed.

module alu #(
  parameter int DATA_W = 64
) (
  input  logic        [1:0]        op,
  input  logic signed [DATA_W-1:0] in1,
  input  logic signed [DATA_W-1:0] in2,
  output logic signed [DATA_W-1:0] out,
  output logic                     of_flag
);

  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  // Opcode decode; signed overflow only exists for add and sub.
  always_comb begin
    out     = '0;
    of_flag = 1'b0;
    case (op)
      2'b00: begin
        out     = sum;
        of_flag = (in1[DATA_W-1] == in2[DATA_W-1]) && (sum[DATA_W-1] != in1[DATA_W-1]);
      end
      2'b01: begin
        out     = diff;
        of_flag = (in1[DATA_W-1] != in2[DATA_W-1]) && (diff[DATA_W-1] != in1[DATA_W-1]);
      end
      2'b10: out = in1 & in2;
      default: out = in1 ^ in2;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic        [1:0]       req0_op,
  input  logic signed [63:0]      req0_a,
  input  logic signed [63:0]      req0_b,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic        [1:0]       req1_op,
  input  logic signed [63:0]      req1_a,
  input  logic signed [63:0]      req1_b,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic signed [63:0]      rsp_result,
  output logic                    rsp_of,
  output logic                    busy,
  output logic        [CNT_W-1:0] of_count
);

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   owner;

  logic                     grant_id;
  logic                     accept;
  logic                     rsp_done;

  logic        [1:0]        op_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;

  logic signed [DATA_W-1:0] alu_out;
  logic                     alu_of;

  // Event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Round-robin choice: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant_id = prio;
    if (req0_valid && !req1_valid)
      grant_id = 1'b0;
    else if (req1_valid && !req0_valid)
      grant_id = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && (grant_id == 1'b0);
  assign req1_ready = (state == IDLE) && req1_valid && (grant_id == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state == RESP) && (owner == 1'b0);
  assign rsp1_valid = (state == RESP) && (owner == 1'b1);
  assign rsp_done   = owner ? rsp1_ready : rsp0_ready;

  assign busy = (state != IDLE);

  // ---- p0: operand capture at grant; later reqN_* changes cannot leak in
  // Operand registers carry no reset: they are only read after a grant.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= grant_id ? req1_op : req0_op;
      a_p0  <= grant_id ? req1_a  : req0_a;
      b_p0  <= grant_id ? req1_b  : req0_b;
    end
  end

  // ---- EXEC: ALU sees only the latched operands
  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op     (op_p0),
    .in1    (a_p0),
    .in2    (b_p0),
    .out    (alu_out),
    .of_flag(alu_of)
  );

  // Sequencer: grant in IDLE, register ALU output in EXEC, hold until taken in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_of     <= 1'b0;
      of_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant_id;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          rsp_of     <= alu_of;
          if (alu_of)
            of_count <= sat_inc(of_count);
          state <= RESP;
        end
        RESP: begin
          // The requester just served loses the next tie.
          if (rsp_done) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [1:0]        req0_op, req1_op;
  logic [63:0]       req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [63:0]       rsp_result;
  logic              rsp_of;
  logic              busy;
  logic [CNT_W-1:0]  of_count;

  int n_chk  = 0;
  int n_pass = 0;
  int prio_m = 0;
  int oc_m   = 0;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .rsp_of    (rsp_of),
    .busy      (busy),
    .of_count  (of_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference ALU from the arithmetic definition: overflow means the exact
  // signed result does not fit in 64 bits.
  function automatic logic [64:0] ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] w;
    logic               o;
    w = '0;
    o = 1'b0;
    case (op)
      2'd0: w = $signed({a[63], a}) + $signed({b[63], b});
      2'd1: w = $signed({a[63], a}) - $signed({b[63], b});
      2'd2: w = {1'b0, a & b};
      default: w = {1'b0, a ^ b};
    endcase
    if (op < 2'd2)
      o = (w > $signed({1'b0, 64'h7FFF_FFFF_FFFF_FFFF})) || (w < $signed({1'b1, 64'h8000_0000_0000_0000}));
    return {o, w[63:0]};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One complete transaction starting in IDLE; stall = cycles rsp_ready is held low.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                         input int stall);
    int          w;
    logic [64:0] r;
    logic [63:0] er;
    logic        eo;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    w = (v0 && v1) ? prio_m : (v0 ? 0 : 1);
    r = (w == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
    er = r[63:0];
    eo = r[64];
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("grant0", req0_ready, w == 0);
    chk("grant1", req1_ready, w == 1);
    @(negedge clk);
    // EXEC: scramble request inputs, they must not affect the result
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'($urandom); req0_a = rnd64(); req0_b = rnd64();
    req1_op = 2'($urandom); req1_a = rnd64(); req1_b = rnd64();
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    @(negedge clk);
    #1;
    if (eo) oc_m = (oc_m < CNT_MAX) ? oc_m + 1 : CNT_MAX;
    chk("rsp0_valid", rsp0_valid, w == 0);
    chk("rsp1_valid", rsp1_valid, w == 1);
    chk("result", rsp_result, er);
    chk("of", rsp_of, eo);
    chk("of_count", of_count, oc_m);
    for (int i = 0; i < stall; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (w == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("stall_busy", busy, 1'b1);
      chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
      chk("stall_valid", {rsp0_valid, rsp1_valid}, (w == 0) ? 2'b10 : 2'b01);
      chk("stall_result", rsp_result, er);
      chk("stall_of", rsp_of, eo);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = (w == 0); rsp1_ready = (w == 1);
    @(posedge clk);
    prio_m = 1 - w;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", rsp_result, 64'h0);
    chk("rst_of", rsp_of, 1'b0);
    chk("rst_count", of_count, 0);
    chk("rst_valid", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 4'b0);
    reset = 1'b0;

    // Directed cases
    run_txn(1, 0, 2'd0, 64'd5, 64'd3, 2'd0, 64'd0, 64'd0, 0);
    run_txn(0, 1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h8000_0000_0000_0000, 64'd1, 0);
    chk("sub_of_cnt", of_count, 1);
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 2'd3, 64'hFF, 64'h0F, 2'd2, 64'hFF, 64'h0F, 0);
    run_txn(1, 0, 2'd0, 64'd100, 64'd23, 2'd0, 64'd0, 64'd0, 10);
    run_txn(0, 1, 2'd0, 64'd0, 64'd0, 2'd3, 64'h1234, 64'h4321, 0);

    // Reset while an operation sits in EXEC
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd7; req0_b = 64'd9;
    @(negedge clk);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_result", rsp_result, 64'h0);
    chk("mid_rst_of", rsp_of, 1'b0);
    chk("mid_rst_count", of_count, 0);
    chk("mid_rst_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    prio_m = 0;
    oc_m   = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", {rsp0_valid, rsp1_valid, busy}, 3'b000);
    end

    // Saturation: 1, 2, 3, 3, 3
    for (int i = 0; i < 5; i++)
      run_txn(0, 1, 2'd0, 64'd0, 64'd0, 2'd1, 64'h8000_0000_0000_0000, 64'd1, 0);
    chk("sat_count", of_count, CNT_MAX);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_txn(v0, v1, 2'($urandom), rnd64(), rnd64(),
              2'($urandom), rnd64(), rnd64(), $urandom_range(0, 2));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 64-bit `alu` instance between two requesters. Each requester presents an opcode and two signed 64-bit operands through a valid/ready handshake. The block latches the winning request, runs it through the ALU, registers the result and overflow flag, and returns them on the winner's response channel. It also keeps a saturating count of overflowing operations.

## Interface
- `CNT_W`, 16, width of the overflow event counter
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `req0_valid` / `req1_valid`  input  1  requester n has an operation pending
- `req0_ready` / `req1_ready`  output  1  block accepts requester n this cycle
- `req0_op` / `req1_op`  input  2  ALU OPCODE: 00 add, 01 sub, 10 and, 11 xor
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  input  64  signed operands (in1, in2)
- `rsp0_valid` / `rsp1_valid`  output  1  result for requester n is available
- `rsp0_ready` / `rsp1_ready`  input  1  requester n takes the result
- `rsp_result`  output  64  registered ALU result, shared by both response channels
- `rsp_of`  output  1  registered ALU OF_FLAG
- `busy`  output  1  high in any state other than IDLE
- `of_count`  output  CNT_W  saturating count of completed operations with OF_FLAG=1

## Operation
- Three-state FSM: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational. If only one `reqN_valid` is high, that requester wins.
  - If both are high, the requester named by the priority pointer `prio` wins (0 or 1).
  - `reqN_ready` is high only for the winner, and only in IDLE.
  - On handshake: latch op, a, b and owner id; go to EXEC.
- **EXEC**
  - The ALU is driven from the latched registers only.
  - On the clock edge, capture ALU out into `rsp_result` and OF_FLAG into `rsp_of`.
  - If OF_FLAG=1 and `of_count` is below all-ones, increment `of_count`.
  - Go to RESP.
- **RESP**
  - `rspN_valid` is high for the owner only.
  - `rsp_result` and `rsp_of` hold stable until the owner's `rspN_ready` is high.
  - On the response handshake: set `prio` to the other requester, go to IDLE.
- Requests are never accepted outside IDLE, so only one operation is in flight.
- `busy` = (state != IDLE).
- The block does no arithmetic itself. Result and flag are the ALU's, bit-for-bit.

## Timing
- Reset values:
  - state = IDLE, `prio` = 0
  - `rsp_result` = 0, `rsp_of` = 0, `of_count` = 0
  - all ready/valid outputs = 0, `busy` = 0
- Latency: request accepted at edge N → `rspN_valid` high after edge N+1. The result is visible in the cycle following EXEC.
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with `rsp_ready` already high).
- The response may stall indefinitely. Outputs and `prio` stay frozen, and the other requester stays unserved.
- A requester that drops `req_valid` before being granted loses nothing; no state is changed.
- Simultaneous requests alternate. After serving requester X, X loses the next tie.
- `prio` updates at response completion, not at grant.
- `reset` asserted in any state:
  - state, registers and counter clear immediately (asynchronous).
  - The in-flight operation is discarded; no response is ever issued for it.
- `of_count` saturates at 2^CNT_W−1 and does not wrap.
- Changes on `reqN_*` inputs after acceptance have no effect on the in-flight operation.

## Test plan
- **Single add.** req0: op=00, a=5, b=3, `rsp0_ready`=1.
  - `req0_ready` high in cycle 0.
  - `rsp0_valid` high 2 cycles later with `rsp_result`=8, `rsp_of`=0.
  - `rsp1_valid` stays 0 throughout.
- **Sub overflow.** req1: op=01, a=0x8000_0000_0000_0000, b=1.
  - `rsp_result`=0x7FFF_FFFF_FFFF_FFFF, `rsp_of`=1, `of_count`=1.
- **Tie arbitration.** Both requesters valid continuously; req0 xor a=0xFF, b=0x0F; req1 and a=0xFF, b=0x0F.
  - Grants go 0, 1, 0, 1.
  - Results alternate 0xF0, 0x0F.
- **Backpressure.** req0 add; hold `rsp0_ready`=0 for 10 cycles while req1 is valid.
  - `rsp0_valid`, `rsp_result` and `busy` stay constant.
  - `req1_ready` stays 0.
  - req1 is granted in the first IDLE cycle after `rsp0_ready` rises.
- **Reset mid-operation.** Accept req0, then assert `reset` during EXEC.
  - All outputs return to reset values in the same cycle.
  - No `rsp0_valid` appears afterward.
  - The next request completes normally.
- **Counter saturation.** With CNT_W=2, run 5 overflowing subs.
  - `of_count` reads 1, 2, 3, 3, 3.
